// File: rtl/mul_pkg.sv
// Package for the iterative shift-and-add multiplier.
// Holds the controller state encoding and the default datapath width
// shared by the multiplier and the parent that owns the adder.
package mul_pkg;

    // Controller states: waiting for a request, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    // Default datapath width (RV32).
    localparam int MUL_WIDTH = 32;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Shared WIDTH-bit adder, carry-in tied to 0, carry-out discarded.
// Sum bits come from per-bit generate/propagate terms with the carry
// chain expressed as g | (p & c).
// Ports:
//   oper1_i  WIDTH  first operand
//   oper2_i  WIDTH  second operand
//   sum_o    WIDTH  (oper1_i + oper2_i) mod 2^WIDTH, combinational
module carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] oper1_i,
    input  logic [WIDTH-1:0] oper2_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] gen_s;
    logic [WIDTH-1:0] prop_s;

    assign gen_s  = oper1_i & oper2_i;
    assign prop_s = oper1_i ^ oper2_i;

    // Carry chain and sum; the carry lives in a process-local variable so
    // the chain is one ordered evaluation rather than a self-dependent vector.
    always_comb begin
        logic carry_s;
        carry_s = 1'b0;
        sum_o   = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = prop_s[i] ^ carry_s;
            carry_s  = gen_s[i] | (prop_s[i] & carry_s);
        end
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-and-add multiplier producing the low WIDTH bits
// of mcand*mplier. Every BUSY cycle it presents {acc, mcand or 0} to an
// external shared adder and captures the sum on the next edge. Always runs
// exactly WIDTH iterations so latency is fixed.
// Ports:
//   clk_i         1      clock, rising edge
//   rstn_i        1      synchronous active-low reset
//   start_i       1      request, accepted when start_i && ready_o
//   mcand_i       WIDTH  multiplicand, sampled on acceptance
//   mplier_i      WIDTH  multiplier, sampled on acceptance
//   ready_o       1      high in IDLE
//   valid_o       1      high in DONE
//   result_i_ack  1      consumer takes the result (only while valid_o)
//   result_o      WIDTH  accumulator, meaningful while valid_o
//   add_oper1_o   WIDTH  to adder oper1_i (0 outside BUSY)
//   add_oper2_o   WIDTH  to adder oper2_i (0 outside BUSY)
//   add_sum_i     WIDTH  from adder sum_o
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             result_i_ack,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] add_oper1_o,
    output logic [WIDTH-1:0] add_oper2_o,
    input  logic [WIDTH-1:0] add_sum_i
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mul_state_t       state_r;
    mul_state_t       state_next_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CNT_W-1:0] cnt_r;

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and adder operand drive; operands stay 0 outside
    // BUSY so the shared adder does not toggle.
    always_comb begin
        state_next_s = state_r;
        add_oper1_o  = {WIDTH{1'b0}};
        add_oper2_o  = {WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                add_oper1_o = acc_r;
                if (mplier_r[0]) begin
                    add_oper2_o = mcand_r;
                end else begin
                    add_oper2_o = {WIDTH{1'b0}};
                end
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (result_i_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, shift/accumulate while BUSY,
    // hold otherwise. cnt wraps to 0 on the final iteration.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        acc_r    <= {WIDTH{1'b0}};
                        mcand_r  <= mcand_i;
                        mplier_r <= mplier_i;
                        cnt_r    <= {CNT_W{1'b0}};
                    end else begin
                        acc_r    <= acc_r;
                        mcand_r  <= mcand_r;
                        mplier_r <= mplier_r;
                        cnt_r    <= cnt_r;
                    end
                end
                BUSY: begin
                    acc_r    <= add_sum_i;
                    mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                default: begin
                    acc_r    <= acc_r;
                    mcand_r  <= mcand_r;
                    mplier_r <= mplier_r;
                    cnt_r    <= cnt_r;
                end
            endcase
        end
    end

    assign ready_o  = (state_r == IDLE);
    assign valid_o  = (state_r == DONE);
    assign result_o = acc_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier, closed-loop with the
// shared carry_lookahead_adder. Expected products are pushed to a
// scoreboard queue at issue time and popped when valid_o appears.
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [W-1:0] mcand;
    logic [W-1:0] mplier;
    logic         ready;
    logic         valid;
    logic         ack;
    logic [W-1:0] result;
    logic [W-1:0] oper1;
    logic [W-1:0] oper2;
    logic [W-1:0] sum;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [W-1:0] sb[$];

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .mcand_i      (mcand),
        .mplier_i     (mplier),
        .ready_o      (ready),
        .valid_o      (valid),
        .result_i_ack (ack),
        .result_o     (result),
        .add_oper1_o  (oper1),
        .add_oper2_o  (oper2),
        .add_sum_i    (sum)
    );

    carry_lookahead_adder #(.WIDTH(W)) adder (
        .oper1_i (oper1),
        .oper2_i (oper2),
        .sum_o   (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request with ready assumed high; returns after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        mcand = a;
        mplier = b;
        start = 1'b1;
        sb.push_back(a * b);
        tick();
        start = 1'b0;
    endtask

    // Count edges after acceptance until valid_o is seen (bounded).
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [W-1:0] sb_pop();
        if (sb.size() == 0) return 32'hxxxx_xxxx;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; ack = 1'b0;
        mcand = 32'd0; mplier = 32'd0;
        tick(); tick();
        rstn = 1'b1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b result=%h, need 1 0 00000000", ready, valid, result);
        end
        checks++;
        if (oper1 !== 32'd0 || oper2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_adder_quiet: oper1=%h oper2=%h, need 0 0", oper1, oper2);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [W-1:0] exp;
        ack = 1'b0;
        issue(32'd3, 32'd5);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_ready_drop: ready=%b, need 0", ready);
        end
        wait_valid(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, need 32", n);
        end
        exp = sb_pop();
        checks++;
        if (result !== exp || exp !== 32'd15) begin
            errors++;
            $display("FAIL basic_result: got %h, need %h", result, 32'd15);
        end
        checks++;
        if (oper1 !== 32'd0 || oper2 !== 32'd0) begin
            errors++;
            $display("FAIL done_adder_quiet: oper1=%h oper2=%h, need 0 0", oper1, oper2);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack_idle: ready=%b valid=%b, need 1 0", ready, valid);
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [W-1:0] exp;
        logic [W-1:0] a_tab [2] = '{32'hFFFF_FFFF, 32'h0001_0000};
        logic [W-1:0] b_tab [2] = '{32'hFFFF_FFFF, 32'h0001_0000};
        logic [W-1:0] r_tab [2] = '{32'h0000_0001, 32'h0000_0000};
        ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            issue(a_tab[i], b_tab[i]);
            wait_valid(n);
            exp = sb_pop();
            checks++;
            if (n !== 32 || result !== exp || result !== r_tab[i]) begin
                errors++;
                $display("FAIL overflow_%0d: got %h after %0d cycles, need %h after 32", i, result, n, r_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_zero_mplier();
        int n;
        logic bad;
        logic [W-1:0] exp;
        ack = 1'b0;
        bad = 1'b0;
        issue(32'hDEAD_BEEF, 32'd0);
        n = 0;
        while (!valid && n < 100) begin
            if (oper2 !== 32'd0 || oper1 !== 32'd0) bad = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL zero_oper2: nonzero adder operand seen in BUSY, need 0");
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL zero_latency: %0d cycles, need 32", n);
        end
        exp = sb_pop();
        checks++;
        if (result !== exp || result !== 32'd0) begin
            errors++;
            $display("FAIL zero_result: got %h, need 00000000", result);
        end
        ack = 1'b1;
        tick();
    endtask

    task automatic test_done_hold();
        int n;
        logic bad;
        logic [W-1:0] exp;
        ack = 1'b0;
        issue(32'h1234_5678, 32'd9);
        wait_valid(n);
        exp = sb_pop();
        checks++;
        if (n !== 32 || result !== exp) begin
            errors++;
            $display("FAIL hold_first: got %h after %0d cycles, need %h after 32", result, n, exp);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            mcand = $urandom();
            mplier = $urandom();
            tick();
            if (valid !== 1'b1 || ready !== 1'b0 || result !== exp) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: valid=%b ready=%b result=%h, need 1 0 %h", valid, ready, result, exp);
        end
        mcand = 32'd21;
        mplier = 32'd2;
        start = 1'b1;
        ack = 1'b1;
        tick();
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_ack_start: ready=%b valid=%b, need 1 0", ready, valid);
        end
        sb.push_back(32'd42);
        tick();
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_accept: ready=%b, need 0", ready);
        end
        wait_valid(n);
        exp = sb_pop();
        checks++;
        if (n !== 32 || result !== exp) begin
            errors++;
            $display("FAIL hold_second: got %h after %0d cycles, need %h after 32", result, n, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W-1:0] exp;
        ack = 1'b1;
        issue(32'd7, 32'd9);
        void'(sb_pop());
        for (int i = 0; i < 12; i++) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL midreset: ready=%b valid=%b result=%h, need 1 0 00000000", ready, valid, result);
        end
        mcand = 32'h0000_1234;
        mplier = 32'h0000_0010;
        start = 1'b1;
        sb.push_back(32'h0001_2340);
        tick();
        start = 1'b0;
        wait_valid(n);
        exp = sb_pop();
        checks++;
        if (n !== 32 || result !== exp) begin
            errors++;
            $display("FAIL midreset_next: got %h after %0d cycles, need %h after 32", result, n, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int t_acc;
        int t_prev;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        ack = 1'b1;
        t_prev = -1;
        for (int i = 0; i < 200; i++) begin
            a = $urandom();
            b = $urandom();
            mcand = a;
            mplier = b;
            start = 1'b1;
            n = 0;
            while (!ready && n < 100) begin
                tick();
                n++;
            end
            tick();
            t_acc = cyc;
            sb.push_back(a * b);
            if (t_prev >= 0) begin
                checks++;
                if (t_acc - t_prev !== 34) begin
                    errors++;
                    $display("FAIL b2b_interval_%0d: %0d cycles, need 34", i, t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            wait_valid(n);
            exp = sb_pop();
            checks++;
            if (n !== 32 || result !== exp) begin
                errors++;
                $display("FAIL b2b_result_%0d: %h*%h got %h after %0d cycles, need %h after 32", i, a, b, result, n, exp);
            end
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_mplier();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Iterative radix-2 shift-and-add multiplier for the RV32 MUL datapath. It produces the low WIDTH bits of the operand product. The block sits directly upstream of the shared carry_lookahead_adder. Each iteration it drives the adder's operand inputs and captures the adder's sum on the next clock edge. The adder stays outside this block, so one adder instance can be shared with the ALU.

Parameters:
WIDTH, 32, operand/result width; must match the adder width.
CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rstn_i  input  1  synchronous, active-low reset.
start_i  input  1  request; accepted when start_i && ready_o.
mcand_i  input  WIDTH  multiplicand; sampled on acceptance.
mplier_i  input  WIDTH  multiplier; sampled on acceptance.
ready_o  output  1  high in IDLE only.
valid_o  output  1  result available; high in DONE only.
result_i_ack  input  1  consumer accepts result; effective only when valid_o=1.
result_o  output  WIDTH  low WIDTH bits of mcand*mplier; valid when valid_o=1.
add_oper1_o  output  WIDTH  to adder oper1_i.
add_oper2_o  output  WIDTH  to adder oper2_i.
add_sum_i  input  WIDTH  from adder sum_o (combinational, same cycle).

Behaviour:
- Reset is sampled on the clock edge with rstn_i=0. It is synchronous and has priority over all other inputs.
  - On reset: state=IDLE, acc=0, mcand_r=0, mplier_r=0, cnt=0.
  - Resulting outputs: ready_o=1, valid_o=0, result_o=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If start_i=1: mcand_r<=mcand_i, mplier_r<=mplier_i, acc<=0, cnt<=0, go to BUSY.
  - Otherwise hold.
- BUSY:
  - Combinational drive: add_oper1_o=acc; add_oper2_o=mcand_r if mplier_r[0]=1, else 0.
  - Each edge: acc<=add_sum_i, mcand_r<=mcand_r<<1 (zero fill, MSB discarded), mplier_r<=mplier_r>>1 (logical), cnt<=cnt+1.
  - When cnt==WIDTH-1 the edge commits the final iteration and moves to DONE. cnt wraps to 0.
  - start_i is ignored (ready_o=0).
- DONE:
  - valid_o=1; result_o=acc, held stable.
  - If result_i_ack=1: go to IDLE on that edge.
  - Otherwise hold indefinitely, with no result loss and no new acceptance.
- Latency: request accepted at edge k; iterations commit at edges k+1..k+WIDTH; valid_o rises after edge k+WIDTH (32 cycles at default).
  - Minimum issue interval: WIDTH+2 cycles (accept, WIDTH iterations, ack).
- Adder outputs in IDLE and DONE: add_oper1_o=0 and add_oper2_o=0, to keep the shared adder quiet.
- Arithmetic:
  - Modulo 2^WIDTH; overflow bits are discarded silently.
  - Low-half result is identical for signed and unsigned operands, so no sign handling is needed.
  - The adder has carry-in 0 and no carry-out; none is required.
- No early termination: always WIDTH iterations, even when the multiplier is 0, so latency is deterministic.
- result_o: reflects acc in all states; it is only meaningful when valid_o=1.
- Reset mid-operation (BUSY or DONE): the operation is abandoned; a new operation can be accepted on the next edge.
- Same-cycle start_i and result_i_ack while in DONE: ack is honoured; start_i is ignored (ready_o=0). The start is accepted the cycle after, in IDLE.

Decomposition:
- Package mul_pkg:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t.
  - localparam MUL_WIDTH=32.
- Single module; no sub-module needed.
- The adder is instantiated at the parent level and connected through the add_* ports.
- The testbench instantiates carry_lookahead_adder alongside the block to close the loop.

Test Plan:
- Reset, then start with mcand=3, mplier=5 -> ready_o drops next cycle; valid_o rises exactly 32 cycles after acceptance; result_o=15.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF -> result_o=0x00000001. mcand=0x00010000, mplier=0x00010000 -> result_o=0x00000000 (overflow discarded).
- mplier=0, mcand=0xDEADBEEF -> still 32 cycles of latency; result_o=0; add_oper2_o=0 throughout BUSY.
- Hold result_i_ack=0 for 10 cycles in DONE while pulsing start_i -> valid_o and result_o are stable and no new operation starts. Then assert ack together with start_i -> IDLE on that edge, and start is accepted on the next edge.
- Assert rstn_i=0 for one edge at iteration 12 of 7*9 -> ready_o=1, valid_o=0, result_o=0. Then 0x1234*0x10 -> 0x00012340.
- 200 random operand pairs issued back-to-back with ack held high -> each result_o matches (a*b) mod 2^32, and the issue interval is exactly 34 cycles.
